// File: rtl/ps2_pkg.sv
// PS/2 receive path shared types and constants.
// Entry layout is {ext, brk, code[7:0]}.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;
  localparam int ENTRY_W = 10;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } entry_t;

  function automatic logic odd_ok(
    input logic [7:0] d,
    input logic       p
  );
    return ^{d, p};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered show-ahead head.
// Head holds its last value while the FIFO is empty.
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW-1:0]    rptr_n;
  logic [CW-1:0]    count_n;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rptr_n  = rptr + AW'(do_pop);
  assign count_n = count + CW'(do_push) - CW'(do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wr_data;
  end

  // New head bypasses memory when it is the slot written this cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      head  <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      rptr  <= rptr_n;
      count <= count_n;
      if (count_n != '0) begin
        if (do_push && (rptr_n == wptr)) head <= wr_data;
        else head <= mem[rptr_n];
      end
    end
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver with prefix merging feeding a key FIFO.
// Sticky error flags report parity, framing/timeout and overflow.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH   = 8,
  parameter int FILT_LEN     = 4,
  parameter int TIMEOUT_CYC  = 100000,
  parameter int MERGE_PREFIX = 1
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  input  logic                          rd,
  input  logic                          clr_err,
  output logic [ENTRY_W-1:0]            data_out,
  output logic                          ready,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          parity_err,
  output logic                          frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]          clk_sync;
  logic [1:0]          data_sync;
  logic [FILT_LEN-1:0] win;
  logic                filt;
  logic                fall;
  logic                sdat;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      win       <= '1;
      filt      <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      win       <= FILT_LEN'({win, clk_sync[1]});
      if (win == '0) filt <= 1'b0;
      else if (&win) filt <= 1'b1;
    end
  end

  assign sdat = data_sync[1];
  assign fall = filt && (win == '0);

  rx_state_t   state;
  logic [2:0]  bitcnt;
  logic [7:0]  shreg;
  logic        par;
  logic [TW-1:0] tout;
  logic        timeout;
  logic        byte_vld;
  logic [7:0]  byte_q;
  logic        perr_evt;
  logic        ferr_evt;

  assign timeout = (state != ST_IDLE) && !fall &&
                   (tout == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= ST_IDLE;
      bitcnt   <= '0;
      shreg    <= '0;
      par      <= 1'b0;
      tout     <= '0;
      byte_vld <= 1'b0;
      byte_q   <= '0;
      perr_evt <= 1'b0;
      ferr_evt <= 1'b0;
    end else begin
      byte_vld <= 1'b0;
      perr_evt <= 1'b0;
      ferr_evt <= 1'b0;
      if (fall || state == ST_IDLE) tout <= '0;
      else tout <= tout + TW'(1);
      if (timeout) begin
        state    <= ST_IDLE;
        ferr_evt <= 1'b1;
        tout     <= '0;
      end else if (fall) begin
        unique case (state)
          ST_IDLE: begin
            if (!sdat) begin
              state  <= ST_DATA;
              bitcnt <= '0;
            end
          end
          ST_DATA: begin
            shreg  <= {sdat, shreg[7:1]};
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) state <= ST_PARITY;
          end
          ST_PARITY: begin
            par   <= sdat;
            state <= ST_STOP;
          end
          ST_STOP: begin
            state <= ST_IDLE;
            if (!sdat) ferr_evt <= 1'b1;
            else if (!odd_ok(shreg, par)) perr_evt <= 1'b1;
            else begin
              byte_vld <= 1'b1;
              byte_q   <= shreg;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  logic   merge;
  logic   is_ext;
  logic   is_brk;
  logic   ext_pend;
  logic   brk_pend;
  logic   push;
  entry_t push_data;

  assign merge  = (MERGE_PREFIX != 0);
  assign is_ext = merge && (byte_q == PS2_EXT);
  assign is_brk = merge && (byte_q == PS2_BRK);
  assign push   = byte_vld && !is_ext && !is_brk;

  always_comb begin
    push_data      = '0;
    push_data.code = byte_q;
    if (merge) begin
      push_data.ext = ext_pend;
      push_data.brk = brk_pend;
    end
  end

  // Prefixes persist across dropped frames until a key byte consumes them.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
    end else if (byte_vld && merge) begin
      if (is_ext) ext_pend <= 1'b1;
      else if (is_brk) brk_pend <= 1'b1;
      else begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end
    end
  end

  logic fifo_full;
  logic fifo_empty;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push    (push),
    .wr_data (push_data),
    .pop     (rd),
    .head    (data_out),
    .count   (count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign ready = !fifo_empty;

  logic ovf_evt;
  assign ovf_evt = push && fifo_full && !rd;

  // Event assignments come last so a same-cycle error beats clr_err.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      overflow   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (clr_err) begin
        overflow   <= 1'b0;
        parity_err <= 1'b0;
        frame_err  <= 1'b0;
      end
      if (ovf_evt)  overflow   <= 1'b1;
      if (perr_evt) parity_err <= 1'b1;
      if (ferr_evt) frame_err  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo with a queue-based reference model.
// A second instance runs with prefix merging disabled.
module tb_ps2_rx_fifo;

  localparam int DEPTH = 4;
  localparam int FILT  = 4;
  localparam int TOUT  = 300;
  localparam int HALF  = 8;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rd0 = 1'b0;
  logic       rd1 = 1'b0;
  logic       clr_err = 1'b0;

  logic [9:0] do0, do1;
  logic       rdy0, rdy1;
  logic [2:0] cnt0, cnt1;
  logic       ov0, ov1, pe0, pe1, fe0, fe1;

  ps2_rx_fifo #(
    .FIFO_DEPTH(DEPTH), .FILT_LEN(FILT),
    .TIMEOUT_CYC(TOUT), .MERGE_PREFIX(1)
  ) dut (
    .clk(clk), .rstn(rstn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rd(rd0), .clr_err(clr_err), .data_out(do0), .ready(rdy0),
    .count(cnt0), .overflow(ov0), .parity_err(pe0), .frame_err(fe0)
  );

  ps2_rx_fifo #(
    .FIFO_DEPTH(DEPTH), .FILT_LEN(FILT),
    .TIMEOUT_CYC(TOUT), .MERGE_PREFIX(0)
  ) dut_raw (
    .clk(clk), .rstn(rstn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rd(rd1), .clr_err(clr_err), .data_out(do1), .ready(rdy1),
    .count(cnt1), .overflow(ov1), .parity_err(pe1), .frame_err(fe1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int push_lat = 8;

  logic [9:0] q[$];
  bit m_ext, m_brk, m_ov, m_pe, m_fe;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] frame_bits(
    input logic [7:0] code, input bit bad_par, input bit bad_stop
  );
    logic p;
    p = ~(^code);
    if (bad_par) p = ~p;
    return {~bad_stop, p, code, 1'b0};
  endfunction

  task automatic drive_fall(input logic b);
    ps2_data = b;
    tick(HALF);
    ps2_clk = 1'b0;
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      drive_fall(bits[i]);
      tick(HALF);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] c, input bit bp, input bit bs);
    send_bits(frame_bits(c, bp, bs), 11);
    ps2_data = 1'b1;
    tick(20);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick(2);
    rstn = 1'b1;
    tick(FILT + 4);
    q.delete();
    m_ext = 0; m_brk = 0; m_ov = 0; m_pe = 0; m_fe = 0;
  endtask

  task automatic pop0();
    rd0 = 1'b1;
    tick(1);
    rd0 = 1'b0;
  endtask

  function automatic void model_frame(
    input logic [7:0] c, input bit bp, input bit bs
  );
    if (bs) m_fe = 1;
    else if (bp) m_pe = 1;
    else if (c == 8'hE0) m_ext = 1;
    else if (c == 8'hF0) m_brk = 1;
    else begin
      if (q.size() == DEPTH) m_ov = 1;
      else q.push_back({m_ext, m_brk, c});
      m_ext = 0;
      m_brk = 0;
    end
  endfunction

  task automatic test_reset();
    rstn = 1'b0;
    tick(3);
    checks++;
    if ({do0, rdy0, cnt0, ov0, pe0, fe0} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0",
               {do0, rdy0, cnt0, ov0, pe0, fe0});
    end
    rstn = 1'b1;
    tick(FILT + 4);
  endtask

  task automatic test_basic();
    logic [10:0] b;
    int lat;
    do_reset();
    b = frame_bits(8'h1C, 0, 0);
    send_bits(b, 10);
    drive_fall(b[10]);
    lat = 0;
    while (!rdy0 && lat < 40) begin
      tick(1);
      lat++;
    end
    push_lat = lat;
    checks++;
    if (lat >= 40 || lat < 2) begin
      errors++;
      $display("FAIL basic_latency: got %0d cycles required 2..39", lat);
    end
    checks++;
    if (do0 !== 10'h01C || cnt0 !== 3'd1) begin
      errors++;
      $display("FAIL basic_head: got %h/%0d required 01c/1", do0, cnt0);
    end
    tick(HALF);
    ps2_clk = 1'b1;
    tick(20);
    pop0();
    checks++;
    if (rdy0 !== 1'b0 || do0 !== 10'h01C) begin
      errors++;
      $display("FAIL basic_pop_hold: got rdy=%b do=%h required 0/01c",
               rdy0, do0);
    end
  endtask

  task automatic test_merge();
    logic [9:0] raw [3];
    raw[0] = 10'h0E0; raw[1] = 10'h0F0; raw[2] = 10'h075;
    do_reset();
    send_frame(8'hE0, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h75, 0, 0);
    checks++;
    if (cnt0 !== 3'd1 || do0 !== 10'h375) begin
      errors++;
      $display("FAIL merge_entry: got %h/%0d required 375/1", do0, cnt0);
    end
    checks++;
    if (cnt1 !== 3'd3) begin
      errors++;
      $display("FAIL raw_count: got %0d required 3", cnt1);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (do1 !== raw[i]) begin
        errors++;
        $display("FAIL raw_entry%0d: got %h required %h", i, do1, raw[i]);
      end
      rd1 = 1'b1;
      tick(1);
      rd1 = 1'b0;
    end
  endtask

  task automatic test_parity();
    do_reset();
    send_frame(8'h1C, 1, 0);
    checks++;
    if (cnt0 !== 3'd0 || pe0 !== 1'b1 || fe0 !== 1'b0) begin
      errors++;
      $display("FAIL parity_set: got cnt=%0d pe=%b fe=%b required 0/1/0",
               cnt0, pe0, fe0);
    end
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    checks++;
    if (pe0 !== 1'b0) begin
      errors++;
      $display("FAIL parity_clear: got %b required 0", pe0);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    send_bits(frame_bits(8'hA5, 0, 0), 5);
    ps2_data = 1'b1;
    tick(TOUT + 20);
    checks++;
    if (fe0 !== 1'b1 || cnt0 !== 3'd0) begin
      errors++;
      $display("FAIL timeout_err: got fe=%b cnt=%0d required 1/0", fe0, cnt0);
    end
    send_frame(8'h32, 0, 0);
    checks++;
    if (do0 !== 10'h032 || cnt0 !== 3'd1) begin
      errors++;
      $display("FAIL timeout_next: got %h/%0d required 032/1", do0, cnt0);
    end
  endtask

  task automatic test_overflow();
    logic [10:0] b;
    logic [7:0] exp [DEPTH];
    do_reset();
    for (int i = 0; i <= DEPTH; i++) send_frame(8'h10 + 8'(i), 0, 0);
    checks++;
    if (cnt0 !== 3'(DEPTH) || ov0 !== 1'b1 || do0 !== 10'h010) begin
      errors++;
      $display("FAIL ovf_full: got cnt=%0d ov=%b do=%h required %0d/1/010",
               cnt0, ov0, do0, DEPTH);
    end
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    checks++;
    if (ov0 !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: got %b required 0", ov0);
    end
    b = frame_bits(8'h20, 0, 0);
    send_bits(b, 10);
    drive_fall(b[10]);
    tick(push_lat - 1);
    rd0 = 1'b1;
    tick(1);
    rd0 = 1'b0;
    checks++;
    if (cnt0 !== 3'(DEPTH) || ov0 !== 1'b0 || do0 !== 10'h011) begin
      errors++;
      $display("FAIL ovf_pushpop: got cnt=%0d ov=%b do=%h required %0d/0/011",
               cnt0, ov0, do0, DEPTH);
    end
    tick(HALF);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    tick(20);
    for (int i = 0; i < DEPTH - 1; i++) exp[i] = 8'h11 + 8'(i);
    exp[DEPTH-1] = 8'h20;
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (do0 !== {2'b00, exp[i]}) begin
        errors++;
        $display("FAIL ovf_drain%0d: got %h required %h", i, do0, exp[i]);
      end
      pop0();
    end
  endtask

  task automatic test_reset_mid();
    logic [10:0] b;
    do_reset();
    b = frame_bits(8'hC3, 0, 0);
    send_bits(b, 6);
    ps2_data = b[6];
    tick(3);
    rstn = 1'b0;
    tick(1);
    rstn = 1'b1;
    checks++;
    if ({do0, rdy0, cnt0, ov0, pe0, fe0} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got %h required 0",
               {do0, rdy0, cnt0, ov0, pe0, fe0});
    end
    ps2_data = 1'b1;
    tick(TOUT + 20);
    send_frame(8'h5A, 0, 0);
    checks++;
    if (do0 !== 10'h05A || cnt0 !== 3'd1 || pe0 !== 1'b0 || fe0 !== 1'b0) begin
      errors++;
      $display("FAIL midreset_next: got do=%h cnt=%0d pe=%b fe=%b required 05a/1/0/0",
               do0, cnt0, pe0, fe0);
    end
  endtask

  task automatic test_random();
    logic [7:0] c;
    int r;
    bit bp, bs;
    do_reset();
    for (int n = 0; n < 30; n++) begin
      r = $urandom_range(0, 9);
      if (r < 2) c = 8'hE0;
      else if (r < 4) c = 8'hF0;
      else c = 8'($urandom_range(0, 8'hDF));
      bp = ($urandom_range(0, 9) == 0);
      bs = ($urandom_range(0, 14) == 0);
      send_frame(c, bp, bs);
      model_frame(c, bp, bs);
      checks++;
      if (int'(cnt0) != q.size() || ov0 !== m_ov || pe0 !== m_pe ||
          fe0 !== m_fe) begin
        errors++;
        $display("FAIL rand_state%0d: got cnt=%0d ov=%b pe=%b fe=%b required %0d/%b/%b/%b",
                 n, cnt0, ov0, pe0, fe0, q.size(), m_ov, m_pe, m_fe);
      end
      if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
        checks++;
        if (do0 !== q[0]) begin
          errors++;
          $display("FAIL rand_head%0d: got %h required %h", n, do0, q[0]);
        end
        pop0();
        void'(q.pop_front());
      end
    end
    while (q.size() > 0) begin
      checks++;
      if (do0 !== q[0]) begin
        errors++;
        $display("FAIL rand_drain: got %h required %h", do0, q[0]);
      end
      pop0();
      void'(q.pop_front());
    end
    checks++;
    if (rdy0 !== 1'b0) begin
      errors++;
      $display("FAIL rand_empty: got ready=%b required 0", rdy0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_merge();
    test_parity();
    test_timeout();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
